keypad_scanner: RTL
===================

// Module: keypad_scanner
// PURPOSE
//  Parametrised ROWSxCOLS matrix-keypad scanner, successor to the fixed 4x4 keypad decoder.
//  Drives columns one at a time, samples rows after a settling dwell, debounces whole scan frames,
//  rejects multi-key (ghosting) frames, and emits one key event per debounced press on a valid/ready port.
//  Sits between the keypad pins and the typing-test character/compare logic.
// PARAMETERS
//  ROWS            4            number of keypad rows (row inputs)
//  COLS            4            number of keypad columns (column drives)
//  CLK_HZ          100_000_000  clk_100MHz frequency in Hz
//  SCAN_US         1000         dwell per column in microseconds; DWELL = CLK_HZ/1_000_000*SCAN_US cycles (>=2)
//  DEBOUNCE_FRAMES 4            consecutive identical frames required to accept a press or release
//  KEY_W           $clog2(ROWS*COLS)  key-code width (localparam, not overridable)
// PORTS
//  clk_100MHz  in   1       system clock
//  rst_n       in   1       synchronous active-low reset
//  row         in   ROWS    keypad rows, active low, pulled up; row[ROWS-1-r] is row r
//  col         out  COLS    column drive, exactly one bit low; col[COLS-1-c] drives column c
//  key_code    out  KEY_W   r*COLS + c of the accepted key; stable while key_valid=1
//  key_valid   out  1       event pending; held until accepted
//  key_ready   in   1       consumer accepts; transfer when key_valid & key_ready
//  key_held    out  1       a debounced key is currently down
//  multi_key   out  1       last completed frame contained >1 pressed key
//  overrun     out  1       1-cycle pulse: new press accepted while previous event not yet taken
// BEHAVIOUR
//  Reset (rst_n=0 at rising edge): col={1'b0,{COLS-1{1'b1}}} (column 0 low); key_code=0, key_valid=0,
//   key_held=0, multi_key=0, overrun=0; dwell counter, column index, frame map, debounce count, FSM -> 0/IDLE.
//   Reset mid-debounce or mid-handshake discards all pending state; no event emitted afterwards for it.
//  Scan: column index c holds for DWELL cycles; row is sampled on the last dwell cycle only, into frame
//   bits [c*ROWS +: ROWS]; then c increments, wrapping COLS-1 -> 0. Frame completes when column COLS-1 sampled.
//  Frame classify (at frame end): none = 0 keys, single = exactly 1 key (index k), multi = >1 key.
//   multi_key registered from each completed frame; updates only at frame end.
//  FSM (advances only at frame end):
//   IDLE:      single -> PRESS_DB (cand=k, cnt=1); none/multi -> IDLE.
//   PRESS_DB:  single & k==cand -> cnt++; cnt reaching DEBOUNCE_FRAMES -> HELD and emit event(cand);
//              anything else -> IDLE (cnt=0).
//   HELD:      key_held=1; single k==cand or multi -> stay (no event); none -> REL_DB (cnt=1);
//              single k!=cand -> stay (new key ignored until full release).
//   REL_DB:    none -> cnt++; cnt reaching DEBOUNCE_FRAMES -> IDLE, key_held=0; any key -> HELD.
//   DEBOUNCE_FRAMES=1: PRESS_DB/REL_DB are passed through in the same frame-end (event on first clean frame).
//  Event: key_valid=1, key_code=cand on the cycle after the accepting frame end.
//   Min press-to-valid latency = DEBOUNCE_FRAMES*COLS*DWELL cycles + 1 after first sampled frame.
//  Handshake: key_valid falls the cycle after key_valid&key_ready; key_code unchanged while valid.
//   New event while key_valid=1 & key_ready=0 on that same cycle: new event dropped, overrun=1 for 1 cycle,
//   old code kept. Simultaneous accept and new event: accept old, load new, key_valid stays 1.
//  key_held rises with key_valid (same cycle), falls the cycle after release debounce completes.
// STRUCTURE
//  keypad_pkg: FSM state enum {IDLE,PRESS_DB,HELD,REL_DB}; function popcount-saturate-to-2; dwell
//   computation function. Sub-module keypad_col_scan (dwell counter, column rotator, frame register,
//   frame_done strobe, none/single/multi + index classify); top holds FSM, debounce, event register.
// TESTING  (CLK_HZ=1_000_000, SCAN_US=4 -> DWELL=4, frame=16 cycles; bench drives row from col + key map)
//  Reset 3 cycles -> col=4'b0111, key_valid=0, key_held=0, multi_key=0, overrun=0; col steps every 4 cycles.
//  Hold r0c2 for 6 frames, key_ready=1 -> exactly one key_valid with key_code=2, key_held=1;
//   release -> key_held=0 after 4 clean frames, no second event.
//  Press r3c1 toggled every frame for 8 frames -> no key_valid, key_held stays 0.
//  Press r1c0 and r2c3 together 6 frames -> multi_key=1 at each frame end, no event; release -> multi_key=0.
//  key_ready=0: press/release r1c1 (code 5), then press r2c1 (code 9) -> key_code stays 5, overrun one
//   1-cycle pulse; raise key_ready -> 5 transferred, key_valid=0 next cycle.
//  Assert rst_n=0 one cycle during PRESS_DB of r0c0 -> no event; key released -> outputs stay at reset values.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the matrix keypad scanner.
//   kp_state_e     debounce/handshake FSM states
//   frame_class_e  classification of one completed scan frame
//   popcount_sat2  number of set bits, saturated at 2 (0, 1, "many")
//   calc_dwell     per-column dwell in clock cycles from clock rate and dwell time
package keypad_pkg;

  localparam int MAX_KEYS = 256;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } kp_state_e;

  typedef enum logic [1:0] {
    FRAME_NONE   = 2'd0,
    FRAME_SINGLE = 2'd1,
    FRAME_MULTI  = 2'd2
  } frame_class_e;

  function automatic logic [1:0] popcount_sat2(input logic [MAX_KEYS-1:0] bits);
    logic [1:0] n;
    n = '0;
    for (int i = 0; i < MAX_KEYS; i++) begin
      if (bits[i] && (n != 2'd2)) n = n + 2'd1;
    end
    return n;
  endfunction

  function automatic int calc_dwell(input int clk_hz, input int scan_us);
    return (clk_hz / 1_000_000) * scan_us;
  endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// keypad_col_scan: column rotator and frame capture for the keypad scanner.
// Holds each column low for DWELL cycles and samples the rows on the last
// dwell cycle into the frame map (bit c*ROWS+r = key r,c pressed).
// Ports:
//   clk_100MHz, rst_n   clock, synchronous active-low reset
//   row_i               keypad rows, active low; row_i[ROWS-1-r] is row r
//   col_o               column drive, one bit low; col_o[COLS-1-c] is column c
//   frame_done_o        1-cycle strobe on the cycle the last column is sampled
//   frame_class_o       none/single/multi for the frame completing this cycle
//   frame_key_o         r*COLS+c of the single pressed key (valid with FRAME_SINGLE)
module keypad_col_scan
  import keypad_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int DWELL = 4,
  localparam int KEY_W = $clog2(ROWS*COLS)
) (
  input  logic               clk_100MHz,
  input  logic               rst_n,
  input  logic [ROWS-1:0]    row_i,
  output logic [COLS-1:0]    col_o,
  output logic               frame_done_o,
  output frame_class_e       frame_class_o,
  output logic [KEY_W-1:0]   frame_key_o
);

  localparam int NK = ROWS * COLS;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW = $clog2(DWELL);

  logic [DW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] col_q, col_d;
  logic [NK-1:0] frame_q, frame_d;
  logic          last_dwell, last_col;
  logic [1:0]    n_keys;

  assign last_dwell   = (dwell_q == DW'(DWELL - 1));
  assign last_col     = (col_q == CW'(COLS - 1));
  assign frame_done_o = last_dwell & last_col;

  always_comb begin
    dwell_d = last_dwell ? '0 : dwell_q + 1'b1;
    col_d   = col_q;
    frame_d = frame_q;
    if (last_dwell) begin
      col_d = last_col ? '0 : col_q + 1'b1;
      for (int r = 0; r < ROWS; r++) begin
        frame_d[int'(col_q)*ROWS + r] = ~row_i[ROWS-1-r];
      end
    end
  end

  always_comb begin
    col_o = '1;
    col_o[COLS-1-int'(col_q)] = 1'b0;
  end

  // Classify frame_d so the frame end sees the column sampled on that same cycle.
  always_comb begin
    n_keys      = popcount_sat2(MAX_KEYS'(frame_d));
    frame_key_o = '0;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (frame_d[c*ROWS + r]) frame_key_o = KEY_W'(r*COLS + c);
      end
    end
    unique case (n_keys)
      2'd0:    frame_class_o = FRAME_NONE;
      2'd1:    frame_class_o = FRAME_SINGLE;
      default: frame_class_o = FRAME_MULTI;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (!rst_n) begin
      dwell_q <= '0;
      col_q   <= '0;
      frame_q <= '0;
    end else begin
      dwell_q <= dwell_d;
      col_q   <= col_d;
      frame_q <= frame_d;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: ROWSxCOLS matrix keypad scanner with frame debounce,
// ghost (multi-key) rejection and a valid/ready key event port.
// Ports:
//   clk_100MHz, rst_n    clock, synchronous active-low reset
//   row / col            keypad pins (rows in, active low; one column driven low)
//   key_code/key_valid   event r*COLS+c, held until key_ready accepts it
//   key_ready            consumer accept
//   key_held             a debounced key is down
//   multi_key            last completed frame had more than one key
//   overrun              1-cycle pulse: new event dropped because the old one was pending
//
// state    | meaning
// IDLE     | no key down, waiting for a single-key frame
// PRESS_DB | counting identical single-key frames for cand
// HELD     | cand accepted and down; other keys ignored until full release
// REL_DB   | counting empty frames before declaring release
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int CLK_HZ          = 100_000_000,
  parameter int SCAN_US         = 1000,
  parameter int DEBOUNCE_FRAMES = 4,
  localparam int KEY_W = $clog2(ROWS*COLS)
) (
  input  logic               clk_100MHz,
  input  logic               rst_n,
  input  logic [ROWS-1:0]    row,
  output logic [COLS-1:0]    col,
  output logic [KEY_W-1:0]   key_code,
  output logic               key_valid,
  input  logic               key_ready,
  output logic               key_held,
  output logic               multi_key,
  output logic               overrun
);

  localparam int DWELL = calc_dwell(CLK_HZ, SCAN_US);
  localparam int CNTW  = $clog2(DEBOUNCE_FRAMES + 1);

  logic               frame_done;
  frame_class_e       frame_class;
  logic [KEY_W-1:0]   frame_key;

  kp_state_e          state_q, state_d;
  logic [KEY_W-1:0]   cand_q, cand_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic               emit;
  logic               valid_q, valid_d;
  logic [KEY_W-1:0]   code_q, code_d;
  logic               multi_q, multi_d;
  logic               overrun_q, overrun_d;

  keypad_col_scan #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .DWELL (DWELL)
  ) u_col_scan (
    .clk_100MHz    (clk_100MHz),
    .rst_n         (rst_n),
    .row_i         (row),
    .col_o         (col),
    .frame_done_o  (frame_done),
    .frame_class_o (frame_class),
    .frame_key_o   (frame_key)
  );

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    emit    = 1'b0;
    if (frame_done) begin
      unique case (state_q)
        IDLE: begin
          if (frame_class == FRAME_SINGLE) begin
            cand_d = frame_key;
            if (DEBOUNCE_FRAMES <= 1) begin
              state_d = HELD;
              cnt_d   = '0;
              emit    = 1'b1;
            end else begin
              state_d = PRESS_DB;
              cnt_d   = CNTW'(1);
            end
          end
        end
        PRESS_DB: begin
          if ((frame_class == FRAME_SINGLE) && (frame_key == cand_q)) begin
            if (cnt_q == CNTW'(DEBOUNCE_FRAMES - 1)) begin
              state_d = HELD;
              cnt_d   = '0;
              emit    = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        HELD: begin
          if (frame_class == FRAME_NONE) begin
            if (DEBOUNCE_FRAMES <= 1) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              state_d = REL_DB;
              cnt_d   = CNTW'(1);
            end
          end
        end
        REL_DB: begin
          if (frame_class == FRAME_NONE) begin
            if (cnt_q == CNTW'(DEBOUNCE_FRAMES - 1)) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            state_d = HELD;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Accept of the old event frees the slot on the same cycle a new one arrives.
  always_comb begin
    valid_d   = valid_q;
    code_d    = code_q;
    overrun_d = 1'b0;
    multi_d   = frame_done ? (frame_class == FRAME_MULTI) : multi_q;
    if (valid_q && key_ready) valid_d = 1'b0;
    if (emit) begin
      if (!valid_q || key_ready) begin
        valid_d = 1'b1;
        code_d  = cand_d;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      code_q    <= '0;
      multi_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      multi_q   <= multi_d;
      overrun_q <= overrun_d;
    end
  end

  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = (state_q == HELD) || (state_q == REL_DB);
  assign multi_key = multi_q;
  assign overrun   = overrun_q;

endmodule
